rtc_bus_ctrl: RTL and testbench
===============================

RTC_BUS_CTRL -- requirements
Module: rtc_bus_ctrl

Interface
REQ-001 Parameter T_SU, default 2: cycles per setup sub-phase, legal 1..15.
REQ-002 Parameter T_PW, default 4: cycles per strobe sub-phase, legal 1..15.
REQ-003 Parameter T_H, default 2: cycles per hold sub-phase, legal 1..15.
REQ-004 Port CLK, input, 1: single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port RST, input, 1: reset, synchronous and active-high.
REQ-006 Port Acceso, input, 1: transaction request from the menu FSM; a rising edge starts a transaction.
REQ-007 Port Dir, input, 8: RTC register address.
REQ-008 Port Mod, input, 1: 1 = write, 0 = read.
REQ-009 Port Dato_wr, input, 8: write data.
REQ-010 Port FRW, output, 1: one-cycle pulse marking the end of a read or write.
REQ-011 Port Dato_rd, output, 8: last read data.
REQ-012 Port Ocupado, output, 1: high while any transaction or the init sequence is in progress.
REQ-013 Ports CS_n, RD_n, WR_n, output, 1 each: active-low RTC strobes.
REQ-014 Port AD_sel, output, 1: 0 = address cycle, 1 = data cycle.
REQ-015 Ports AD_out, output, 8, and AD_oe, output, 1: AD bus drive value and drive enable.
REQ-016 Port AD_in, input, 8: AD bus sampled value.

Function
REQ-017 The FSM SHALL have these states: INIT, IDLE, A_SU, A_PW, A_H, D_SU, D_PW, D_H, DONE.
- A_SU, D_SU last T_SU cycles; A_PW, D_PW last T_PW cycles; A_H, D_H last T_H cycles; DONE lasts 1 cycle.
- Sequence: A_SU to A_PW to A_H to D_SU to D_PW to D_H to DONE to IDLE.
REQ-018 Start condition:
- Acceso_ant is a registered copy of Acceso.
- If the block is in IDLE and Acceso=1 and Acceso_ant=0 at edge N, it SHALL enter A_SU at edge N+1.
- Dir, Mod and Dato_wr SHALL be captured at edge N.
REQ-019 Address states (A_*):
- AD_sel=0, AD_oe=1, AD_out=captured Dir.
- CS_n=0 and WR_n=0 only in A_PW.
REQ-020 Write data states (D_*, Mod=1):
- AD_sel=1, AD_oe=1, AD_out=captured Dato_wr.
- CS_n=0 and WR_n=0 only in D_PW.
REQ-021 Read data states (D_*, Mod=0):
- AD_sel=1, AD_oe=0.
- CS_n=0 and RD_n=0 only in D_PW.
- Dato_rd SHALL load AD_in on the last D_PW cycle and hold until the next read completes.
REQ-022 FRW SHALL be 1 only in DONE. With default parameters, FRW is high at edge N+17.
REQ-023 Rising edges of Acceso outside IDLE SHALL be ignored and not queued.
- An Acceso still high on return to IDLE SHALL NOT retrigger; a fresh rising edge is required.
REQ-024 Changes on Dir, Mod or Dato_wr after capture SHALL have no effect on the transaction in progress.
REQ-025 In IDLE, INIT waits and DONE: CS_n=RD_n=WR_n=1, AD_oe=0, AD_sel=1.
REQ-026 Ocupado SHALL be 0 only in IDLE.
REQ-027 Phase counter: 4 bits, loaded at each state entry, state advances when the count reaches terminal. It SHALL NOT wrap.

Reset
REQ-028 When RST=1 at an edge, the following SHALL hold at that edge regardless of state (including mid-strobe):
- CS_n=RD_n=WR_n=1, AD_sel=1, AD_oe=0, AD_out=0, Dato_rd=0, FRW=0, Acceso_ant=0.
- State SHALL be INIT, with Ocupado=1.
REQ-029 The first post-reset state action SHALL occur on the first edge with RST=0.

Configuration
REQ-030 Macro RTC_INIT_SEQ_EN, when defined, enables the init sequence in INIT:
- Two back-to-back writes, each a full write transaction with its own FRW pulse: Dir=8'h02 Dato=8'h10, then Dir=8'h02 Dato=8'h00.
- After the second FRW the block goes to IDLE.
- Acceso edges during init are ignored.
REQ-031 When RTC_INIT_SEQ_EN is undefined, INIT SHALL go to IDLE on the first edge after reset release, and no FRW is emitted.

Structure
REQ-032 The shared package rtc_bus_pkg SHALL hold:
- the state enumeration;
- the default T_SU/T_PW/T_H;
- the init constants INIT_DIR=8'h02, INIT_D0=8'h10, INIT_D1=8'h00.
REQ-033 The phase counter SHALL be a sub-module rtc_phase_timer with inputs load, load value and tick, and output done.

Verification
REQ-034 Write: Dir=8'h21, Mod=1, Dato_wr=8'h45, Acceso rising edge at N ->
- AD_out=21 with WR_n low for 4 cycles, then AD_out=45 with WR_n low for 4 cycles;
- FRW at N+17; RD_n never low.
REQ-035 Read: Dir=8'h24, Mod=0, AD_in=8'h3A during D_PW ->
- RD_n low for 4 cycles, AD_oe=0 in D_*;
- Dato_rd=8'h3A when FRW=1.
REQ-036 Acceso held high for 30 cycles -> exactly one transaction and one FRW.
REQ-037 Second Acceso rising edge at N+5 -> ignored; a third edge after FRW -> a new transaction starts.
REQ-038 RST asserted during A_PW -> all strobes high at that edge, Dato_rd=0.
- With RTC_INIT_SEQ_EN: two FRW pulses before Ocupado falls.
REQ-039 RTC_INIT_SEQ_EN undefined -> Ocupado=0 on the second edge after RST deasserts, and no FRW.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus controller.
package rtc_bus_pkg;

  localparam int unsigned T_SU_DEF = 2;
  localparam int unsigned T_PW_DEF = 4;
  localparam int unsigned T_H_DEF  = 2;
  localparam int unsigned PH_W     = 4;

  localparam logic [7:0] INIT_DIR = 8'h02;
  localparam logic [7:0] INIT_D0  = 8'h10;
  localparam logic [7:0] INIT_D1  = 8'h00;

  typedef enum logic [3:0] {
    INIT,
    IDLE,
    A_SU,
    A_PW,
    A_H,
    D_SU,
    D_PW,
    D_H,
    DONE
  } state_e;

endpackage

// File: rtl/rtc_phase_timer.sv
// Down-counting phase timer: loaded on state entry, saturates at zero, done when count is zero.
module rtc_phase_timer
  import rtc_bus_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PH_W-1:0] load_val,
  input  logic            tick,
  output logic            done
);

  logic [PH_W-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - PH_W'(1);
    end
    done_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Multiplexed address/data bus controller for an RTC chip: address cycle, then write or read data cycle.
// Define RTC_INIT_SEQ_EN to run two start-up register writes from INIT before accepting requests.
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_SU = T_SU_DEF,
  parameter int unsigned T_PW = T_PW_DEF,
  parameter int unsigned T_H  = T_H_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Acceso,
  input  logic [7:0] Dir,
  input  logic       Mod,
  input  logic [7:0] Dato_wr,
  output logic       FRW,
  output logic [7:0] Dato_rd,
  output logic       Ocupado,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       AD_sel,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  input  logic [7:0] AD_in
);

  state_e          state_q, state_d;
  logic            acceso_ant_q, acceso_ant_d;
  logic            start_q, start_d;
  logic [7:0]      dir_q, dir_d;
  logic            mod_q, mod_d;
  logic [7:0]      wdat_q, wdat_d;
  logic [7:0]      rdat_q, rdat_d;
  logic            frw_q, frw_d;
  logic            ocupado_q, ocupado_d;
  logic            cs_n_q, cs_n_d;
  logic            rd_n_q, rd_n_d;
  logic            wr_n_q, wr_n_d;
  logic            ad_sel_q, ad_sel_d;
  logic            ad_oe_q, ad_oe_d;
  logic [7:0]      ad_out_q, ad_out_d;
  logic            ph_load;
  logic [PH_W-1:0] ph_val;
  logic            ph_done;
  logic            a_ph, d_ph;
`ifdef RTC_INIT_SEQ_EN
  logic            init_busy_q, init_busy_d;
  logic            init_pend_q, init_pend_d;
`endif

  function automatic logic [PH_W-1:0] dur_m1(input state_e s);
    case (s)
      A_SU, D_SU: dur_m1 = PH_W'(T_SU - 1);
      A_PW, D_PW: dur_m1 = PH_W'(T_PW - 1);
      A_H, D_H:   dur_m1 = PH_W'(T_H - 1);
      default:    dur_m1 = '0;
    endcase
  endfunction

  rtc_phase_timer u_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (ph_load),
    .load_val (ph_val),
    .tick     (1'b1),
    .done     (ph_done)
  );

  // Next state, captured request and strobe/bus values aligned with the next state
  always_comb begin
    state_d      = state_q;
    acceso_ant_d = Acceso;
    start_d      = 1'b0;
    dir_d        = dir_q;
    mod_d        = mod_q;
    wdat_d       = wdat_q;
    rdat_d       = rdat_q;
`ifdef RTC_INIT_SEQ_EN
    init_busy_d  = init_busy_q;
    init_pend_d  = init_pend_q;
`endif

    case (state_q)
      INIT: begin
`ifdef RTC_INIT_SEQ_EN
        dir_d       = INIT_DIR;
        mod_d       = 1'b1;
        wdat_d      = INIT_D0;
        init_busy_d = 1'b1;
        init_pend_d = 1'b1;
        state_d     = A_SU;
`else
        state_d = IDLE;
`endif
      end
      IDLE: begin
        if (start_q) begin
          state_d = A_SU;
        end else if (Acceso && !acceso_ant_q) begin
          start_d = 1'b1;
          dir_d   = Dir;
          mod_d   = Mod;
          wdat_d  = Dato_wr;
        end
      end
      A_SU: if (ph_done) state_d = A_PW;
      A_PW: if (ph_done) state_d = A_H;
      A_H:  if (ph_done) state_d = D_SU;
      D_SU: if (ph_done) state_d = D_PW;
      D_PW: begin
        if (ph_done) begin
          state_d = D_H;
          if (!mod_q) rdat_d = AD_in;
        end
      end
      D_H:  if (ph_done) state_d = DONE;
      DONE: begin
`ifdef RTC_INIT_SEQ_EN
        if (init_busy_q && init_pend_q) begin
          wdat_d      = INIT_D1;
          init_pend_d = 1'b0;
          state_d     = A_SU;
        end else begin
          init_busy_d = 1'b0;
          state_d     = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = INIT;
    endcase

    ph_load = (state_d != state_q);
    ph_val  = dur_m1(state_d);

    a_ph      = (state_d == A_SU) || (state_d == A_PW) || (state_d == A_H);
    d_ph      = (state_d == D_SU) || (state_d == D_PW) || (state_d == D_H);
    cs_n_d    = !((state_d == A_PW) || (state_d == D_PW));
    wr_n_d    = !((state_d == A_PW) || ((state_d == D_PW) && mod_d));
    rd_n_d    = !((state_d == D_PW) && !mod_d);
    ad_sel_d  = !a_ph;
    ad_oe_d   = a_ph || (d_ph && mod_d);
    ad_out_d  = a_ph ? dir_d : ((d_ph && mod_d) ? wdat_d : 8'h00);
    frw_d     = (state_d == DONE);
    ocupado_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= INIT;
      acceso_ant_q <= 1'b0;
      start_q      <= 1'b0;
      dir_q        <= 8'h00;
      mod_q        <= 1'b0;
      wdat_q       <= 8'h00;
      rdat_q       <= 8'h00;
      frw_q        <= 1'b0;
      ocupado_q    <= 1'b1;
      cs_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      ad_sel_q     <= 1'b1;
      ad_oe_q      <= 1'b0;
      ad_out_q     <= 8'h00;
`ifdef RTC_INIT_SEQ_EN
      init_busy_q  <= 1'b0;
      init_pend_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      acceso_ant_q <= acceso_ant_d;
      start_q      <= start_d;
      dir_q        <= dir_d;
      mod_q        <= mod_d;
      wdat_q       <= wdat_d;
      rdat_q       <= rdat_d;
      frw_q        <= frw_d;
      ocupado_q    <= ocupado_d;
      cs_n_q       <= cs_n_d;
      rd_n_q       <= rd_n_d;
      wr_n_q       <= wr_n_d;
      ad_sel_q     <= ad_sel_d;
      ad_oe_q      <= ad_oe_d;
      ad_out_q     <= ad_out_d;
`ifdef RTC_INIT_SEQ_EN
      init_busy_q  <= init_busy_d;
      init_pend_q  <= init_pend_d;
`endif
    end
  end

  assign FRW     = frw_q;
  assign Dato_rd = rdat_q;
  assign Ocupado = ocupado_q;
  assign CS_n    = cs_n_q;
  assign RD_n    = rd_n_q;
  assign WR_n    = wr_n_q;
  assign AD_sel  = ad_sel_q;
  assign AD_oe   = ad_oe_q;
  assign AD_out  = ad_out_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Scoreboard bench for rtc_bus_ctrl: expected transactions queued at request, checked on each FRW pulse.
module tb_rtc_bus_ctrl;

  logic       CLK = 1'b0;
  logic       RST, Acceso, Mod;
  logic [7:0] Dir, Dato_wr, AD_in, rtc_val;
  logic       FRW, Ocupado, CS_n, RD_n, WR_n, AD_sel, AD_oe;
  logic [7:0] Dato_rd, AD_out;

  rtc_bus_ctrl dut (
    .CLK     (CLK),
    .RST     (RST),
    .Acceso  (Acceso),
    .Dir     (Dir),
    .Mod     (Mod),
    .Dato_wr (Dato_wr),
    .FRW     (FRW),
    .Dato_rd (Dato_rd),
    .Ocupado (Ocupado),
    .CS_n    (CS_n),
    .RD_n    (RD_n),
    .WR_n    (WR_n),
    .AD_sel  (AD_sel),
    .AD_out  (AD_out),
    .AD_oe   (AD_oe),
    .AD_in   (AD_in)
  );

  always #5 CLK = ~CLK;

  // RTC model: drives read data only while RD_n is low
  assign AD_in = RD_n ? 8'hEE : rtc_val;

  typedef struct {
    logic       mod;
    logic [7:0] dir;
    logic [7:0] dat;
    logic [7:0] rd;
    int         frw_cyc;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_frw = 0;
  int         n_exp = 0;
  int         wr_a = 0, wr_d = 0, rd_c = 0, cs_c = 0;
  logic       frw_prev = 1'b0;
  logic [7:0] last_rd = 8'h00;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bus monitor: count strobe cycles per transaction, compare against scoreboard on FRW
  always @(negedge CLK) begin
    if (RST) begin
      wr_a = 0; wr_d = 0; rd_c = 0; cs_c = 0;
      frw_prev = 1'b0;
    end else begin
      if (sbq.size() > 0) begin
        if (!WR_n && !AD_sel && AD_oe && AD_out == sbq[0].dir) wr_a++;
        if (!WR_n && AD_sel && AD_oe && AD_out == sbq[0].dat) wr_d++;
      end
      if (!RD_n && AD_sel && !AD_oe) rd_c++;
      if (!CS_n) cs_c++;
      if (frw_prev) check("frw_pulse", FRW, 0);
      if (FRW) begin
        n_frw++;
        if (sbq.size() == 0) begin
          check("frw_unexpected", FRW, 0);
        end else begin
          mon_e = sbq.pop_front();
          check("frw_cycle", cyc, mon_e.frw_cyc);
          check("dato_rd", Dato_rd, mon_e.rd);
          check("wr_addr_cycles", wr_a, 4);
          check("wr_data_cycles", wr_d, mon_e.mod ? 4 : 0);
          check("rd_cycles", rd_c, mon_e.mod ? 0 : 4);
          check("cs_cycles", cs_c, 8);
        end
        wr_a = 0; wr_d = 0; rd_c = 0; cs_c = 0;
      end
      frw_prev = FRW;
    end
  end

  task automatic push_exp(input logic mod, input logic [7:0] dir, input logic [7:0] dat,
                          input logic [7:0] rval, input int frw_cyc);
    exp_t e;
    e.mod = mod; e.dir = dir; e.dat = dat; e.frw_cyc = frw_cyc;
    e.rd = mod ? last_rd : rval;
    if (!mod) last_rd = rval;
    sbq.push_back(e);
    n_exp++;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge CLK);
      if (!Ocupado) break;
    end
    check("idle_reached", Ocupado, 0);
  endtask

  // Raise Acceso one ns after an edge; the next edge is the start edge N, FRW expected at N+17
  task automatic start_txn(input logic [7:0] dir, input logic mod, input logic [7:0] dat,
                           input logic [7:0] rval);
    @(posedge CLK);
    #1;
    Dir = dir; Mod = mod; Dato_wr = dat; rtc_val = rval; Acceso = 1'b1;
    push_exp(mod, dir, dat, rval, cyc + 18);
  endtask

  // Full transaction; request fields are scrambled after capture to prove they are held
  task automatic txn(input logic [7:0] dir, input logic mod, input logic [7:0] dat,
                     input logic [7:0] rval, input int hold);
    start_txn(dir, mod, dat, rval);
    repeat (hold) @(posedge CLK);
    #1;
    Acceso = 1'b0; Dir = ~dir; Mod = ~mod; Dato_wr = ~dat;
    if (hold < 10) begin
      @(negedge CLK);
      @(negedge CLK);
      check("busy", Ocupado, 1);
    end
    wait_idle(40);
  endtask

  task automatic check_reset_outputs();
    check("rst_cs_n", CS_n, 1);
    check("rst_rd_n", RD_n, 1);
    check("rst_wr_n", WR_n, 1);
    check("rst_ad_sel", AD_sel, 1);
    check("rst_ad_oe", AD_oe, 0);
    check("rst_ad_out", AD_out, 0);
    check("rst_dato_rd", Dato_rd, 0);
    check("rst_frw", FRW, 0);
    check("rst_ocupado", Ocupado, 1);
  endtask

  task automatic do_release();
    @(posedge CLK);
    #1;
    RST = 1'b0;
`ifdef RTC_INIT_SEQ_EN
    push_exp(1'b1, rtc_bus_pkg::INIT_DIR, rtc_bus_pkg::INIT_D0, 8'h00, cyc + 17);
    push_exp(1'b1, rtc_bus_pkg::INIT_DIR, rtc_bus_pkg::INIT_D1, 8'h00, cyc + 34);
`endif
    @(posedge CLK);
    @(negedge CLK);
`ifdef RTC_INIT_SEQ_EN
    check("init_busy", Ocupado, 1);
    wait_idle(80);
    check("init_done_q", sbq.size(), 0);
`else
    check("release_ocupado", Ocupado, 0);
    check("release_frw", FRW, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; Acceso = 1'b0; Mod = 1'b0; Dir = 8'h00; Dato_wr = 8'h00; rtc_val = 8'h00;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs();
    do_release();

    txn(8'h21, 1'b1, 8'h45, 8'h00, 1);
    txn(8'h24, 1'b0, 8'h00, 8'h3A, 1);
    txn(8'h5A, 1'b1, 8'hC3, 8'h00, 2);

    // Acceso held high well past the end of the transaction
    txn(8'h30, 1'b1, 8'h77, 8'h00, 30);
    repeat (5) @(negedge CLK);
    check("no_retrigger", Ocupado, 0);

    // Second rising edge at N+5 must be dropped, a later one must start a new transaction
    start_txn(8'h41, 1'b0, 8'h00, 8'h5C);
    repeat (3) @(posedge CLK);
    #1 Acceso = 1'b0;
    repeat (2) @(posedge CLK);
    #1 Acceso = 1'b1;
    @(posedge CLK);
    #1 Acceso = 1'b0;
    @(negedge CLK);
    check("busy_ignored_edge", Ocupado, 1);
    wait_idle(40);
    repeat (3) @(negedge CLK);
    check("ignored_edge_idle", Ocupado, 0);
    txn(8'h42, 1'b1, 8'h99, 8'h00, 2);

    // Reset while the address strobe is active
    start_txn(8'h55, 1'b1, 8'h66, 8'h00);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (!CS_n) break;
    end
    check("reached_a_pw", CS_n, 0);
    check("a_pw_addr", AD_out, 8'h55);
    check("a_pw_wr_n", WR_n, 0);
    RST = 1'b1;
    Acceso = 1'b0;
    sbq.delete();
    n_exp--;
    last_rd = 8'h00;
    @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs();
    do_release();

    // One more read after the mid-strobe reset
    txn(8'h24, 1'b0, 8'h00, 8'hA5, 1);

    repeat (4) @(negedge CLK);
    check("sb_empty", sbq.size(), 0);
    check("frw_total", n_frw, n_exp);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
